// File: rtl/ddr3_pkg.sv
// ddr3_pkg: command codes, DDR3 pin encodings and burst constants shared by the DFI scheduler.
package ddr3_pkg;
    localparam logic [2:0] CMD_ACT  = 3'd0;
    localparam logic [2:0] CMD_RD   = 3'd1;
    localparam logic [2:0] CMD_WR   = 3'd2;
    localparam logic [2:0] CMD_PRE  = 3'd3;
    localparam logic [2:0] CMD_PREA = 3'd4;
    localparam logic [2:0] CMD_REF  = 3'd5;
    localparam logic [2:0] CMD_NOP  = 3'd6;

    // {cs, ras, cas, we}, active low
    localparam logic [3:0] PINS_ACT  = 4'b0011;
    localparam logic [3:0] PINS_RD   = 4'b0101;
    localparam logic [3:0] PINS_WR   = 4'b0100;
    localparam logic [3:0] PINS_PRE  = 4'b0010;
    localparam logic [3:0] PINS_REF  = 4'b0001;
    localparam logic [3:0] PINS_IDLE = 4'b1111;

    localparam int BL8_BEATS = 4;

    function automatic logic [3:0] cmd_pins(input logic [2:0] code);
        return code == CMD_ACT ? PINS_ACT :
               code == CMD_RD  ? PINS_RD  :
               code == CMD_WR  ? PINS_WR  :
               (code == CMD_PRE || code == CMD_PREA) ? PINS_PRE :
               code == CMD_REF ? PINS_REF : PINS_IDLE;
    endfunction
endpackage

// File: rtl/ddr3_gap_timer.sv
// ddr3_gap_timer: saturating down-counter that enforces a minimum gap of GAP cycles after a load.
module ddr3_gap_timer #(
    parameter int GAP = 1,
    parameter int W   = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    output logic [W-1:0] value,
    output logic         zero
);
    localparam logic [W-1:0] INIT = W'(GAP > 0 ? GAP - 1 : 0);

    always_ff @(posedge clock) begin
        if (reset)
            value <= '0;
        else if (load)
            value <= INIT;
        else if (value != '0)
            value <= value - 1'b1;
    end

    assign zero = (value == '0);
endmodule

// File: rtl/ddr3_dfi_sched.sv
// ddr3_dfi_sched: issues one abstract command at a time onto the DFI pins, enforcing global
// DDR3 gap timers and generating the BL8 write/read data windows.
module ddr3_dfi_sched
    import ddr3_pkg::*;
#(
    parameter int DDR3_WIDTH = 16,
    parameter int ADDR_BITS  = 14,
    parameter int CL         = 6,
    parameter int CWL        = 5,
    parameter int TRCD       = 6,
    parameter int TRP        = 6,
    parameter int TRFC       = 64,
    parameter int TWR        = 6,
    parameter int TWTR       = 4,
    parameter int TCCD       = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [2:0]                cmd_code_i,
    input  logic [2:0]                cmd_bank_i,
    input  logic [ADDR_BITS-1:0]      cmd_addr_i,
    output logic                      wr_next_o,
    input  logic [2*DDR3_WIDTH/8-1:0] wr_mask_i,
    input  logic [2*DDR3_WIDTH-1:0]   wr_data_i,
    output logic                      dfi_cs_no,
    output logic                      dfi_ras_no,
    output logic                      dfi_cas_no,
    output logic                      dfi_we_no,
    output logic [2:0]                dfi_bank_o,
    output logic [ADDR_BITS-1:0]      dfi_addr_o,
    output logic                      dfi_odt_o,
    output logic                      dfi_wstb_o,
    output logic                      dfi_wren_o,
    output logic [2*DDR3_WIDTH/8-1:0] dfi_mask_o,
    output logic [2*DDR3_WIDTH-1:0]   dfi_data_o,
    output logic                      dfi_rden_o,
    output logic                      busy_o
);
    localparam int WP = CWL + BL8_BEATS;
    localparam int RP = CL + BL8_BEATS;
    localparam int TW = $clog2(TRCD + TCCD + TWTR + TWR + TRP + TRFC + CL + 2 * CWL + 16);
    localparam int T_RCD = 0, T_CCD = 1, T_WTR = 2, T_RTW = 3;
    localparam int T_RTP = 4, T_WTP = 5, T_RP = 6, T_RFC = 7;
    localparam int GAPS [8] = '{TRCD, TCCD, CWL + BL8_BEATS + TWTR, CL + TCCD + 2 - CWL,
                                BL8_BEATS, CWL + BL8_BEATS + TWR, TRP, TRFC};

    logic is_act, is_rd, is_wr, is_pre, is_prea, is_ref, issue, tmr_busy;
    logic [7:0]           ld, z;
    logic [TW-1:0]        tv [8];
    logic [ADDR_BITS-1:0] addr_fix;
    logic [WP-1:0]        wr_pipe;
    logic [RP-1:0]        rd_pipe;
    logic                 odt_tail;

    assign is_act  = cmd_code_i == CMD_ACT;
    assign is_rd   = cmd_code_i == CMD_RD;
    assign is_wr   = cmd_code_i == CMD_WR;
    assign is_pre  = cmd_code_i == CMD_PRE;
    assign is_prea = cmd_code_i == CMD_PREA;
    assign is_ref  = cmd_code_i == CMD_REF;

    for (genvar g = 0; g < 8; g++) begin : g_tmr
        ddr3_gap_timer #(.GAP(GAPS[g]), .W(TW)) u_tmr (
            .clock(clock),
            .reset(reset),
            .load (ld[g]),
            .value(tv[g]),
            .zero (z[g])
        );
    end

    always_comb begin
        cmd_ready_o = is_rd ? z[T_RCD] & z[T_CCD] & z[T_WTR] & z[T_RFC] :
                      is_wr ? z[T_RCD] & z[T_CCD] & z[T_RTW] & z[T_RFC] :
                      (is_act | is_ref) ? z[T_RP] & z[T_RFC] :
                      (is_pre | is_prea) ? z[T_WTP] & z[T_RTP] & z[T_RFC] : 1'b1;
        issue = cmd_valid_i & cmd_ready_o & (cmd_code_i < CMD_NOP);
        ld = issue ? {is_ref, is_pre | is_prea, is_wr, is_rd, is_rd, is_wr, is_rd | is_wr, is_act} : 8'd0;
        // A10 carries auto-precharge on RD/WR and the all-banks select on PRE/PREA
        addr_fix = (is_act | is_ref) ? cmd_addr_i : {cmd_addr_i[ADDR_BITS-1:11], is_prea, cmd_addr_i[9:0]};
        tmr_busy = 1'b0;
        for (int k = 0; k < 8; k++)
            tmr_busy = tmr_busy | (tv[k] != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            {dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no} <= PINS_IDLE;
            dfi_bank_o <= '0;
            dfi_addr_o <= '0;
            wr_pipe    <= '0;
            rd_pipe    <= '0;
            odt_tail   <= 1'b0;
            dfi_data_o <= '0;
            dfi_mask_o <= '0;
        end else begin
            {dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no} <= issue ? cmd_pins(cmd_code_i) : PINS_IDLE;
            if (issue) begin
                dfi_bank_o <= cmd_bank_i;
                dfi_addr_o <= addr_fix;
            end
            // each issue ORs a burst into the head, so TCCD-spaced bursts merge into one window
            wr_pipe  <= {wr_pipe[WP-2:0], 1'b0} | {{(WP-BL8_BEATS){1'b0}}, {BL8_BEATS{issue & is_wr}}};
            rd_pipe  <= {rd_pipe[RP-2:0], 1'b0} | {{(RP-BL8_BEATS){1'b0}}, {BL8_BEATS{issue & is_rd}}};
            odt_tail <= dfi_wren_o;
            if (wr_next_o) begin
                dfi_data_o <= wr_data_i;
                dfi_mask_o <= wr_mask_i;
            end
        end
    end

    assign wr_next_o  = wr_pipe[WP-2];
    assign dfi_wren_o = wr_pipe[WP-1];
    assign dfi_wstb_o = wr_next_o & ~dfi_wren_o;
    assign dfi_odt_o  = wr_next_o | dfi_wren_o | odt_tail;
    assign dfi_rden_o = rd_pipe[RP-1];
    assign busy_o     = (|wr_pipe) | (|rd_pipe) | odt_tail | tmr_busy;
endmodule

// File: tb/tb_ddr3_dfi_sched.sv
// tb_ddr3_dfi_sched: random command streams checked against a cycle-indexed model built from
// command issue times and the DDR3 gap/latency rules.
module tb_ddr3_dfi_sched;
    localparam int DDR3_WIDTH = 16, ADDR_BITS = 14, CL = 6, CWL = 5, TRCD = 6, TRP = 6;
    localparam int TRFC = 64, TWR = 6, TWTR = 4, TCCD = 4;
    localparam int DW = 2 * DDR3_WIDTH, MW = 2 * DDR3_WIDTH / 8;
    localparam int NEVER = -100000;
    localparam int CYCLES = 6000;

    logic                 clock = 1'b0, reset = 1'b1, cmd_valid_i = 1'b0;
    logic                 cmd_ready_o, wr_next_o;
    logic [2:0]           cmd_code_i = 3'd6, cmd_bank_i = 3'd0;
    logic [ADDR_BITS-1:0] cmd_addr_i = '0;
    logic [MW-1:0]        wr_mask_i = '0, dfi_mask_o;
    logic [DW-1:0]        wr_data_i = '0, dfi_data_o;
    logic                 dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no;
    logic [2:0]           dfi_bank_o;
    logic [ADDR_BITS-1:0] dfi_addr_o;
    logic                 dfi_odt_o, dfi_wstb_o, dfi_wren_o, dfi_rden_o, busy_o;

    ddr3_dfi_sched dut (
        .clock(clock), .reset(reset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_code_i(cmd_code_i),
        .cmd_bank_i(cmd_bank_i), .cmd_addr_i(cmd_addr_i),
        .wr_next_o(wr_next_o), .wr_mask_i(wr_mask_i), .wr_data_i(wr_data_i),
        .dfi_cs_no(dfi_cs_no), .dfi_ras_no(dfi_ras_no), .dfi_cas_no(dfi_cas_no), .dfi_we_no(dfi_we_no),
        .dfi_bank_o(dfi_bank_o), .dfi_addr_o(dfi_addr_o), .dfi_odt_o(dfi_odt_o),
        .dfi_wstb_o(dfi_wstb_o), .dfi_wren_o(dfi_wren_o), .dfi_mask_o(dfi_mask_o),
        .dfi_data_o(dfi_data_o), .dfi_rden_o(dfi_rden_o), .busy_o(busy_o)
    );

    always #5 clock = ~clock;

    int vectors = 0, miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    int last_act, last_rdwr, last_rd, last_wr, last_pre, last_ref;
    int wr_q[$], rd_q[$];

    function automatic bit wr_win(int n, int lo, int hi);
        foreach (wr_q[i]) if (n >= wr_q[i] + lo && n <= wr_q[i] + hi) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit rd_win(int n, int lo, int hi);
        foreach (rd_q[i]) if (n >= rd_q[i] + lo && n <= rd_q[i] + hi) return 1'b1;
        return 1'b0;
    endfunction

    // minimum gaps measured between acceptance cycles
    function automatic bit model_ready(int code, int n);
        bit rfc_ok = n >= last_ref + TRFC;
        case (code)
            0, 5:    return rfc_ok && n >= last_pre + TRP;
            1:       return rfc_ok && n >= last_act + TRCD && n >= last_rdwr + TCCD && n >= last_wr + CWL + 4 + TWTR;
            2:       return rfc_ok && n >= last_act + TRCD && n >= last_rdwr + TCCD && n >= last_rd + CL + TCCD + 2 - CWL;
            3, 4:    return rfc_ok && n >= last_wr + CWL + 4 + TWR && n >= last_rd + 4;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit model_busy(int n);
        return n < last_act + TRCD || n < last_rdwr + TCCD || n < last_rd + CL + TCCD + 2 - CWL ||
               n < last_rd + 4 || n < last_wr + CWL + 4 + TWTR || n < last_wr + CWL + 4 + TWR ||
               n < last_pre + TRP || n < last_ref + TRFC || wr_win(n, 1, CWL + 5) || rd_win(n, 1, CL + 4);
    endfunction

    function automatic logic [3:0] pins_of(int code);
        case (code)
            0:       return 4'b0011;
            1:       return 4'b0101;
            2:       return 4'b0100;
            3, 4:    return 4'b0010;
            5:       return 4'b0001;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic int addr_of(int code, int a);
        if (code == 1 || code == 2 || code == 3) return a & ~(1 << 10);
        if (code == 4) return a | (1 << 10);
        return a;
    endfunction

    task automatic clear_model();
        last_act = NEVER; last_rdwr = NEVER; last_rd = NEVER;
        last_wr = NEVER; last_pre = NEVER; last_ref = NEVER;
        wr_q.delete();
        rd_q.delete();
    endtask

    int code, prev_code, prev_issue, prev_bank, prev_addr, r;
    bit rst_now, prev_rst, acc, prev_wrn, exp_next;
    logic [DW-1:0] exp_data, prev_wdata;
    logic [MW-1:0] exp_mask, prev_wmask;
    logic [2:0] exp_bank;
    logic [ADDR_BITS-1:0] exp_addr;

    initial begin
        clear_model();
        prev_rst = 1'b1; prev_issue = -1; prev_code = 6; prev_wrn = 1'b0;
        exp_data = '0; exp_mask = '0; exp_bank = '0; exp_addr = '0;
        prev_bank = 0; prev_addr = 0; prev_wdata = '0; prev_wmask = '0;
        for (int n = 0; n < CYCLES; n++) begin
            @(posedge clock);
            #1;
            rst_now = n < 3 || $urandom_range(0, 399) == 0;
            r = $urandom_range(0, 99);
            code = $urandom_range(0, 1) == 1 ? prev_code :
                   r < 15 ? 0 : r < 40 ? 1 : r < 65 ? 2 : r < 75 ? 3 : r < 80 ? 4 : r < 83 ? 5 : 6 + (r & 1);
            reset       = rst_now;
            cmd_valid_i = !rst_now && $urandom_range(0, 9) < 7;
            cmd_code_i  = code[2:0];
            cmd_bank_i  = 3'($urandom);
            cmd_addr_i  = ADDR_BITS'($urandom);
            wr_data_i   = DW'($urandom);
            wr_mask_i   = MW'($urandom);
            @(negedge clock);
            if (n > 0) begin
                if (prev_rst) begin
                    exp_bank = '0; exp_addr = '0; exp_data = '0; exp_mask = '0;
                end else begin
                    if (prev_issue >= 0) begin
                        exp_bank = 3'(prev_bank);
                        exp_addr = ADDR_BITS'(prev_addr);
                    end
                    if (prev_wrn) begin
                        exp_data = prev_wdata;
                        exp_mask = prev_wmask;
                    end
                end
                exp_next = wr_win(n, CWL, CWL + 3);
                chk("pins", {dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no},
                    (prev_rst || prev_issue < 0) ? 4'b1111 : pins_of(prev_issue));
                chk("bank", dfi_bank_o, exp_bank);
                chk("addr", dfi_addr_o, exp_addr);
                chk("wr_next", wr_next_o, exp_next);
                chk("wren", dfi_wren_o, wr_win(n, CWL + 1, CWL + 4));
                chk("wstb", dfi_wstb_o, exp_next && !wr_win(n, CWL + 1, CWL + 4));
                chk("odt", dfi_odt_o, wr_win(n, CWL, CWL + 5));
                chk("rden", dfi_rden_o, rd_win(n, CL + 1, CL + 4));
                chk("data", dfi_data_o, exp_data);
                chk("mask", dfi_mask_o, exp_mask);
                chk("busy", busy_o, model_busy(n));
                chk("ready", cmd_ready_o, model_ready(code, n));
            end
            acc        = !rst_now && cmd_valid_i && model_ready(code, n) && code < 6;
            prev_wrn   = wr_win(n, CWL, CWL + 3);
            prev_wdata = wr_data_i;
            prev_wmask = wr_mask_i;
            prev_bank  = int'(cmd_bank_i);
            prev_addr  = addr_of(code, int'(cmd_addr_i));
            prev_issue = acc ? code : -1;
            prev_rst   = rst_now;
            prev_code  = code;
            if (rst_now) clear_model();
            else if (acc) begin
                case (code)
                    0: last_act = n;
                    1: begin last_rd = n; last_rdwr = n; rd_q.push_back(n); end
                    2: begin last_wr = n; last_rdwr = n; wr_q.push_back(n); end
                    3, 4: last_pre = n;
                    default: last_ref = n;
                endcase
                while (wr_q.size() > 0 && wr_q[0] < n - 40) void'(wr_q.pop_front());
                while (rd_q.size() > 0 && rd_q[0] < n - 40) void'(rd_q.pop_front());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
